nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 116 +++++++++++
 tb/tb_nibble_serial_adder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Bit-serial-by-nibble adder: one 4-bit adder slice is reused once per nibble, LSB nibble first.
// Valid/ready handshake on both sides; the result is held in DONE until downstream takes it.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk_in,
  input  logic                 rstn_in,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  input  logic                 c_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic [4*NIBBLES-1:0] s_out,
  output logic                 c_out,
  output logic                 valid_out,
  input  logic                 ready_in
);

  localparam int W  = 4 * NIBBLES;
  // One spare bit so the counter can step past the last nibble without wrapping.
  localparam int CW = $clog2(NIBBLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, a_next;
  logic [W-1:0]    b_reg, b_next;
  logic            carry_reg, carry_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [W-1:0]    s_reg, s_next;
  logic            c_reg, c_next;

  logic [CW+1:0]   shift_amt;
  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [4:0]      sum5;

  // Nibble k sits at bit offset 4k; shifting by {k, 2'b00} avoids variable part-selects.
  assign shift_amt = {cnt_reg, 2'b00};
  assign a_nib     = 4'(a_reg >> shift_amt);
  assign b_nib     = 4'(b_reg >> shift_amt);
  assign sum5      = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_reg};

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      s_reg     <= '0;
      c_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
      s_reg     <= s_next;
      c_reg     <= c_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    s_next     = s_reg;
    c_next     = c_reg;

    case (state_reg)
      IDLE: begin
        if (valid_in) begin
          a_next     = a_in;
          b_next     = b_in;
          carry_next = c_in;
          cnt_next   = '0;
          s_next     = '0;
          c_next     = 1'b0;
          state_next = ADD;
        end
      end
      ADD: begin
        // s_reg was cleared on accept, so OR-ing in each new nibble is sufficient.
        s_next     = s_reg | (W'(sum5[3:0]) << shift_amt);
        carry_next = sum5[4];
        cnt_next   = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
          c_next     = sum5[4];
          state_next = DONE;
        end
      end
      DONE: begin
        if (ready_in) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ready_out = (state_reg == IDLE) && rstn_in;
  assign valid_out = (state_reg == DONE);
  assign s_out     = s_reg;
  assign c_out     = c_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4): latency, carry chain, backpressure,
// mid-operation reset and operand isolation, with hand-computed expected results.
module tb_nibble_serial_adder;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk_in = 1'b0;
  logic         rstn_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         c_in;
  logic         valid_in;
  logic         ready_out;
  logic [W-1:0] s_out;
  logic         c_out;
  logic         valid_out;
  logic         ready_in;

  int errors = 0;
  int checks = 0;

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk_in    (clk_in),
    .rstn_in   (rstn_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .s_out     (s_out),
    .c_out     (c_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Accept one operation, check latency, then hold in DONE for hold_cycles edges before transfer.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] exp_s, input logic exp_c,
                        input int hold_cycles);
    a_in     = a;
    b_in     = b;
    c_in     = cin;
    valid_in = 1'b1;
    ready_in = (hold_cycles == 0);
    check({tag, "_ready_before"}, 32'(ready_out), 32'd1);
    step();
    valid_in = 1'b0;
    a_in     = ~a;
    b_in     = 16'h5A5A;
    c_in     = ~cin;
    for (int i = 0; i < NIB; i++) begin
      check({tag, "_busy_valid"}, 32'(valid_out), 32'd0);
      check({tag, "_busy_ready"}, 32'(ready_out), 32'd0);
      step();
    end
    check({tag, "_valid"}, 32'(valid_out), 32'd1);
    check({tag, "_sum"}, 32'(s_out), 32'(exp_s));
    check({tag, "_cout"}, 32'(c_out), 32'(exp_c));
    for (int i = 0; i < hold_cycles; i++) begin
      step();
      check({tag, "_hold_valid"}, 32'(valid_out), 32'd1);
      check({tag, "_hold_sum"}, 32'(s_out), 32'(exp_s));
      check({tag, "_hold_cout"}, 32'(c_out), 32'(exp_c));
    end
    ready_in = 1'b1;
    step();
    check({tag, "_xfer_valid"}, 32'(valid_out), 32'd0);
    check({tag, "_xfer_ready"}, 32'(ready_out), 32'd1);
    check({tag, "_kept_sum"}, 32'(s_out), 32'(exp_s));
    check({tag, "_kept_cout"}, 32'(c_out), 32'(exp_c));
    $display("op %s: a=%h b=%h cin=%0d -> s=%h cout=%0d", tag, a, b, cin, s_out, c_out);
  endtask

  initial begin
    rstn_in  = 1'b0;
    a_in     = '0;
    b_in     = '0;
    c_in     = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    #1;
    check("rst_ready", 32'(ready_out), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_sum", 32'(s_out), 32'd0);
    check("rst_cout", 32'(c_out), 32'd0);
    step();
    step();
    #3 rstn_in = 1'b1;
    #1;
    check("post_rst_ready", 32'(ready_out), 32'd1);
    step();

    run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
    run_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0);
    run_op("bkpr", 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 3);

    // Reset in the middle of ADD: partial sum is 0x0055 at this point and must vanish at once.
    a_in = 16'h1234; b_in = 16'h4321; c_in = 1'b0; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    step();
    #2 rstn_in = 1'b0;
    #1;
    check("midrst_sum", 32'(s_out), 32'd0);
    check("midrst_cout", 32'(c_out), 32'd0);
    check("midrst_valid", 32'(valid_out), 32'd0);
    check("midrst_ready", 32'(ready_out), 32'd0);
    step();
    #2 rstn_in = 1'b1;
    #1;
    check("midrst_release_ready", 32'(ready_out), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("midrst_no_result", 32'(valid_out), 32'd0);
    end
    $display("op midrst: abandoned, s=%h valid=%0d", s_out, valid_out);
    run_op("after_rst", 16'h0008, 16'h0008, 1'b0, 16'h0010, 1'b0, 0);

    // valid_in stays high with changing operands while busy; only the accepted pair counts.
    a_in = 16'h0A0B; b_in = 16'h0102; c_in = 1'b1; valid_in = 1'b1; ready_in = 1'b0;
    step();
    a_in = 16'hFFFF; b_in = 16'hFFFF; c_in = 1'b1;
    for (int i = 0; i < NIB; i++) begin
      check("iso_busy_valid", 32'(valid_out), 32'd0);
      a_in = a_in - 16'h1111;
      step();
    end
    check("iso_valid", 32'(valid_out), 32'd1);
    check("iso_sum", 32'(s_out), 32'h0B0E);
    check("iso_cout", 32'(c_out), 32'd0);
    step();
    check("iso_done_hold", 32'(valid_out), 32'd1);
    ready_in = 1'b1;
    step();
    check("iso_xfer_valid", 32'(valid_out), 32'd0);
    check("iso_xfer_ready", 32'(ready_out), 32'd1);
    valid_in = 1'b0;
    step();
    check("iso_single_result", 32'(valid_out), 32'd0);
    check("iso_idle_ready", 32'(ready_out), 32'd1);
    $display("op iso: s=%h cout=%0d", s_out, c_out);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
